uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 607, clock cycles per UART bit (70 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_i  input  1  asynchronous serial line, idle high, 8N1 (8E1 with parity option), LSB first.
REQ-005 SHALL have port data_o  output  8  received byte, stable while valid_o=1.
REQ-006 SHALL have port valid_o  output  1  byte available to the downstream debug-protocol decoder.
REQ-007 SHALL have port ready_i  input  1  downstream accepts byte; transfer occurs when valid_o & ready_i.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse on stop-bit (or parity) error.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH with a 16-bit bit-timer and 3-bit bit index.
REQ-012 IDLE: on rxs=0 SHALL load timer with BAUD_DIV/2 (integer division) and enter START.
REQ-013 START: at timer expiry SHALL sample rxs; 0 -> load timer BAUD_DIV, index 0, enter DATA; 1 -> glitch, return to IDLE with no pulse.
REQ-014 DATA: at each expiry SHALL shift rxs into the shift register MSB-side (LSB first on wire), reload BAUD_DIV; after index 7 enter PARITY if enabled else STOP.
REQ-015 STOP: at expiry rxs=1 SHALL complete the byte and enter IDLE; rxs=0 SHALL pulse frame_err_o, discard the byte, enter WAIT_HIGH.
REQ-016 WAIT_HIGH: SHALL remain until rxs=1, then enter IDLE (a held break generates exactly one frame_err_o).
REQ-017 Output holding register: on completion with valid_o=0, or valid_o=1 and ready_i=1 in the same cycle, SHALL load data_o and set valid_o the following cycle.
REQ-018 On completion with valid_o=1 and ready_i=0 SHALL keep old data_o, drop the new byte, pulse overrun_o.
REQ-019 valid_o SHALL clear the cycle after a transfer unless a simultaneous reload per REQ-017 occurs.
REQ-020 Latency rx_i falling edge to valid_o SHALL be 2 + BAUD_DIV/2 + 9*BAUD_DIV (+BAUD_DIV with parity) + 1 cycles, +/-1.
REQ-021 Receiver SHALL continue receiving while valid_o=1; backpressure never stalls the FSM.

Reset
REQ-022 rst_i=1 SHALL force state IDLE, synchronizer flops to 1, timer/index/shift register 0, data_o=8'h00, valid_o=0, frame_err_o=0, overrun_o=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; first byte after release requires a fresh start bit.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: PARITY state SHALL sample the even-parity bit; mismatch pulses frame_err_o, discards the byte, enters STOP-skip to WAIT_HIGH after stop-bit time.
REQ-025 UART_RX_PARITY_EN undefined: PARITY state and parity logic SHALL be absent; frame is 8N1.

Verification (BAUD_DIV=8)
REQ-026 Send 0xA5, ready_i=1 -> single valid_o cycle with data_o=0xA5, no error pulses.
REQ-027 rx_i low for 3 cycles then high -> glitch rejected, valid_o stays 0, no frame_err_o.
REQ-028 Send 0x3C with stop bit 0, then line high -> one frame_err_o pulse, valid_o stays 0; next byte 0x81 received correctly.
REQ-029 ready_i=0, send 0x11 then 0x22 -> data_o=0x11 held, one overrun_o pulse; ready_i=1 -> 0x11 transferred, valid_o clears.
REQ-030 Assert rst_i during DATA bit 4 of 0xFF, release, send 0x5A -> only 0x5A appears on data_o.
REQ-031 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> frame_err_o pulse, no valid_o; with parity 1 -> data_o=0x07.

Source files
------------

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : uart_rx_frontend                                             |
// | Brief   : 8N1 UART receiver with a 2-flop synchronizer, a 16x-free     |
// |           mid-bit sampling FSM and a valid/ready output register.      |
// |           Define UART_RX_PARITY_EN for 8E1 (even parity) frames.       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module uart_rx_frontend #(
    parameter int BAUD_DIV = 607
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam logic [15:0] c_BAUD = 16'(BAUD_DIV);
    localparam logic [15:0] c_HALF = 16'(BAUD_DIV / 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic        r_sync1;
    logic        r_sync2;
    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_frame_err;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_overrun;

    logic        w_rxs;
    logic        w_expire;
    logic        w_par_err;
    logic        w_complete;

`ifdef UART_RX_PARITY_EN
    logic        r_par_err;
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    assign w_rxs      = r_sync2;
    // A loaded count of N expires N cycles later, on the cycle it reads 1.
    assign w_expire   = (r_timer == 16'd1);
    assign w_complete = (r_state == S_STOP) && w_expire && w_rxs && !w_par_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_sync1     <= rx_i;
            r_sync2     <= r_sync1;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_timer <= c_HALF;
                        r_state <= S_START;
`ifdef UART_RX_PARITY_EN
                        r_par_err <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (w_expire) begin
                        if (!w_rxs) begin
                            r_timer <= c_BAUD;
                            r_idx   <= 3'd0;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_expire) begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_timer <= c_BAUD;
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_expire) begin
                        r_timer <= c_BAUD;
                        r_state <= S_STOP;
                        if (w_rxs != (^r_shift)) begin
                            r_par_err   <= 1'b1;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_expire) begin
                        // A parity failure already reported; just let the stop bit pass.
                        if (w_par_err) begin
                            r_state <= S_WAIT_HIGH;
                        end else if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding register: backpressure drops new bytes instead of stalling the receiver.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete && (!r_valid || ready_i)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_uart_rx_frontend                                          |
// | Brief   : Directed, table-driven bench for uart_rx_frontend at         |
// |           BAUD_DIV=8; parity cases enabled with UART_RX_PARITY_EN.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_uart_rx_frontend;

    localparam int c_BD = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;

    int n_checks = 0;
    int n_errors = 0;

    // Running totals kept by the monitor; tests work on differences.
    int         tot_valid = 0;
    int         tot_xfer  = 0;
    int         tot_ferr  = 0;
    int         tot_ovr   = 0;
    logic [7:0] last_valid_data = 8'h00;
    logic [7:0] last_xfer_data  = 8'h00;

    uart_rx_frontend #(.BAUD_DIV(c_BD)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (ferr),
        .overrun_o   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            tot_valid       <= tot_valid + 1;
            last_valid_data <= data;
        end
        if (valid && ready) begin
            tot_xfer       <= tot_xfer + 1;
            last_xfer_data <= data;
        end
        if (ferr) tot_ferr <= tot_ferr + 1;
        if (ovr)  tot_ovr  <= tot_ovr + 1;
    end

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       rdy;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (c_BD) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic idle(input int bits);
        for (int i = 0; i < bits; i++) drive_bit(1'b1);
    endtask

    vec_t vecs [6];
    int   v0, f0, o0, x0;

    initial begin
        vecs[0] = '{din: 8'hA5, stop: 1'b1, rdy: 1'b1, exp_data: 8'hA5, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};
        vecs[1] = '{din: 8'h00, stop: 1'b1, rdy: 1'b1, exp_data: 8'h00, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};
        vecs[2] = '{din: 8'hFF, stop: 1'b1, rdy: 1'b1, exp_data: 8'hFF, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};
        vecs[3] = '{din: 8'h3C, stop: 1'b0, rdy: 1'b1, exp_data: 8'h00, exp_valid: 0, exp_ferr: 1, exp_ovr: 0};
        vecs[4] = '{din: 8'h81, stop: 1'b1, rdy: 1'b1, exp_data: 8'h81, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};
        vecs[5] = '{din: 8'h6E, stop: 1'b1, rdy: 1'b1, exp_data: 8'h6E, exp_valid: 1, exp_ferr: 0, exp_ovr: 0};

        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset data_o",  int'(data),  0);
        chk("reset valid_o", int'(valid), 0);
        chk("reset frame_err_o", int'(ferr), 0);
        chk("reset overrun_o", int'(ovr), 0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            ready = vecs[i].rdy;
            v0 = tot_valid; f0 = tot_ferr; o0 = tot_ovr;
            send_byte(vecs[i].din, vecs[i].stop, 1'b0);
            idle(2);
            chk($sformatf("vec%0d valid cycles", i), tot_valid - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d frame_err", i), tot_ferr - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d overrun", i), tot_ovr - o0, vecs[i].exp_ovr);
            if (vecs[i].exp_valid > 0)
                chk($sformatf("vec%0d data", i), int'(last_valid_data), int'(vecs[i].exp_data));
        end

        // Start-bit glitch: low for 3 cycles only.
        v0 = tot_valid; f0 = tot_ferr;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(3);
        chk("glitch valid", tot_valid - v0, 0);
        chk("glitch frame_err", tot_ferr - f0, 0);

        // Held break: one frame error only, then recovery.
        f0 = tot_ferr; v0 = tot_valid;
        drive_bit(1'b0);
        for (int i = 0; i < 14; i++) drive_bit(1'b0);
        idle(2);
        chk("break frame_err", tot_ferr - f0, 1);
        chk("break valid", tot_valid - v0, 0);

        // Backpressure: second byte dropped with overrun.
        ready = 1'b0;
        o0 = tot_ovr; x0 = tot_xfer;
        send_byte(8'h11, 1'b1, 1'b0);
        idle(1);
        send_byte(8'h22, 1'b1, 1'b0);
        idle(2);
        chk("ovr data held", int'(data), 8'h11);
        chk("ovr valid held", int'(valid), 1);
        chk("ovr pulse count", tot_ovr - o0, 1);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr transfers", tot_xfer - x0, 1);
        chk("ovr xfer data", int'(last_xfer_data), 8'h11);
        chk("ovr valid cleared", int'(valid), 0);

        // Reset during data bit 4 of 0xFF, then 0x5A.
        v0 = tot_valid; f0 = tot_ferr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        chk("midreset valid", tot_valid - v0, 0);
        chk("midreset data_o", int'(data), 0);
        send_byte(8'h5A, 1'b1, 1'b0);
        idle(2);
        chk("post-reset valid", tot_valid - v0, 1);
        chk("post-reset data", int'(last_valid_data), 8'h5A);
        chk("post-reset frame_err", tot_ferr - f0, 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: correct even-parity bit is 1.
        v0 = tot_valid; f0 = tot_ferr;
        send_byte(8'h07, 1'b1, 1'b1);
        idle(2);
        chk("parity bad frame_err", tot_ferr - f0, 1);
        chk("parity bad valid", tot_valid - v0, 0);
        send_byte(8'h07, 1'b1, 1'b0);
        idle(2);
        chk("parity good valid", tot_valid - v0, 1);
        chk("parity good data", int'(last_valid_data), 8'h07);
        chk("parity good frame_err", tot_ferr - f0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
